// File: rtl/galvo_dac_sequencer.sv
// galvo_dac_sequencer
//   Drives a dual-channel 12-bit DAC (MCP4822-style) through a 16-bit SPI
//   transmitter. Each accepted (x, y) point becomes two SPI words. Channel A
//   carries X and channel B carries Y. An active-low LDAC pulse follows the
//   second word so both galvo axes update together.
//
// Ports
//   clock_in, reset_in       system clock, async active-high reset
//   x_in, y_in               12-bit point coordinates
//   point_valid_in           point present on x_in/y_in
//   point_ready_out          sequencer will accept a point on this edge
//   spi_data_out             word presented to the SPI transmitter; held from start until busy falls
//   spi_length_out           transfer length, constant 16
//   spi_start_out            one-cycle start pulse to the SPI transmitter
//   spi_busy_in              SPI transmitter busy
//   ldac_out                 DAC latch strobe, active-low
//   error_out                sticky: transmitter never went busy after a start
//   clear_error_in           clears error_out; a simultaneous new error wins
//   points_sent_out          completed points, wraps 65535 -> 0
module galvo_dac_sequencer #(
  parameter int unsigned GAP_CYCLES    = 8,
  parameter int unsigned LDAC_CYCLES   = 4,
  parameter int unsigned START_TIMEOUT = 4,
  parameter bit          GAIN_1X       = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        point_valid_in,
  output logic        point_ready_out,
  output logic [15:0] spi_data_out,
  output logic [5:0]  spi_length_out,
  output logic        spi_start_out,
  input  logic        spi_busy_in,
  output logic        ldac_out,
  output logic        error_out,
  input  logic        clear_error_in,
  output logic [15:0] points_sent_out
);

  typedef enum logic [3:0] {
    IDLE,
    START_X,
    WAIT_X_HI,
    WAIT_X_LO,
    GAP,
    START_Y,
    WAIT_Y_HI,
    WAIT_Y_LO,
    LDAC
  } state_t;

  localparam logic [15:0] GAP_LOAD     = 16'(GAP_CYCLES);
  localparam logic [15:0] LDAC_LOAD    = 16'(LDAC_CYCLES);
  localparam logic [15:0] TIMEOUT_LAST = (START_TIMEOUT == 0) ? 16'd0 : 16'(START_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [15:0] data_q, data_d;
  logic        start_q, start_d;
  logic        ldac_q, ldac_d;
  logic        error_q, error_d;
  logic [15:0] count_q, count_d;
  logic [15:0] points_sent_q, points_sent_d;
  logic [11:0] y_q, y_d;
  logic        timeout;
  logic [15:0] x_word;
  logic [15:0] y_word;

  // DAC command word: [15] channel B, [14] unused, [13] GA, [12] SHDN (1 = active)
  assign x_word = {1'b0, 1'b0, GAIN_1X, 1'b1, x_in};
  assign y_word = {1'b1, 1'b0, GAIN_1X, 1'b1, y_q};

  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    data_d        = data_q;
    start_d       = 1'b0;
    ldac_d        = ldac_q;
    error_d       = error_q;
    count_d       = count_q;
    points_sent_d = points_sent_q;
    y_d           = y_q;
    timeout       = 1'b0;

    case (state_q)
      IDLE: begin
        ldac_d  = 1'b1;
        ready_d = ~spi_busy_in;
        // busy also gates acceptance: ready_q lags busy by one cycle
        if (point_valid_in && ready_q && !spi_busy_in) begin
          y_d     = y_in;
          data_d  = x_word;
          start_d = 1'b1;
          ready_d = 1'b0;
          state_d = START_X;
        end
      end

      START_X: begin
        count_d = '0;
        state_d = WAIT_X_HI;
      end

      WAIT_X_HI: begin
        if (spi_busy_in) begin
          state_d = WAIT_X_LO;
        end else if (count_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      WAIT_X_LO: begin
        if (!spi_busy_in) begin
          if (GAP_CYCLES == 0) begin
            data_d  = y_word;
            start_d = 1'b1;
            state_d = START_Y;
          end else begin
            count_d = GAP_LOAD;
            state_d = GAP;
          end
        end
      end

      GAP: begin
        if (count_q <= 16'd1) begin
          data_d  = y_word;
          start_d = 1'b1;
          state_d = START_Y;
        end else begin
          count_d = count_q - 16'd1;
        end
      end

      START_Y: begin
        count_d = '0;
        state_d = WAIT_Y_HI;
      end

      WAIT_Y_HI: begin
        if (spi_busy_in) begin
          state_d = WAIT_Y_LO;
        end else if (count_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + 16'd1;
        end
      end

      WAIT_Y_LO: begin
        if (!spi_busy_in) begin
          ldac_d  = 1'b0;
          count_d = LDAC_LOAD;
          state_d = LDAC;
        end
      end

      LDAC: begin
        if (count_q <= 16'd1) begin
          ldac_d        = 1'b1;
          points_sent_d = points_sent_q + 16'd1;
          ready_d       = 1'b1;
          state_d       = IDLE;
        end else begin
          count_d = count_q - 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // set has priority over clear
    if (clear_error_in) error_d = 1'b0;
    if (timeout)        error_d = 1'b1;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      data_q        <= '0;
      start_q       <= 1'b0;
      ldac_q        <= 1'b1;
      error_q       <= 1'b0;
      count_q       <= '0;
      points_sent_q <= '0;
      y_q           <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      data_q        <= data_d;
      start_q       <= start_d;
      ldac_q        <= ldac_d;
      error_q       <= error_d;
      count_q       <= count_d;
      points_sent_q <= points_sent_d;
      y_q           <= y_d;
    end
  end

  assign point_ready_out = ready_q;
  assign spi_data_out    = data_q;
  assign spi_length_out  = 6'd16;
  assign spi_start_out   = start_q;
  assign ldac_out        = ldac_q;
  assign error_out       = error_q;
  assign points_sent_out = points_sent_q;

endmodule

// File: tb/tb_galvo_dac_sequencer.sv
// tb_galvo_dac_sequencer
//   Self-checking bench for galvo_dac_sequencer with a behavioural SPI
//   transmitter stub. The stub can respond to every start, to no start, or
//   to X words only.
module tb_galvo_dac_sequencer;

  localparam int unsigned GAP   = 8;
  localparam int unsigned LDACN = 4;
  localparam int unsigned TOUT  = 4;
  localparam int unsigned XFER  = 20;
  localparam int          BOUND = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] x_in;
  logic [11:0] y_in;
  logic        point_valid_in;
  logic        point_ready_out;
  logic [15:0] spi_data_out;
  logic [5:0]  spi_length_out;
  logic        spi_start_out;
  logic        spi_busy_in;
  logic        ldac_out;
  logic        error_out;
  logic        clear_error_in;
  logic [15:0] points_sent_out;

  logic        stub_busy;
  logic [7:0]  stub_cnt;
  logic        glitch;
  int          stub_mode;   // 0 respond always, 1 never, 2 X words only

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign spi_busy_in = stub_busy | glitch;

  galvo_dac_sequencer #(
    .GAP_CYCLES   (GAP),
    .LDAC_CYCLES  (LDACN),
    .START_TIMEOUT(TOUT),
    .GAIN_1X      (1'b1)
  ) dut (
    .clock_in       (clk),
    .reset_in       (rst),
    .x_in           (x_in),
    .y_in           (y_in),
    .point_valid_in (point_valid_in),
    .point_ready_out(point_ready_out),
    .spi_data_out   (spi_data_out),
    .spi_length_out (spi_length_out),
    .spi_start_out  (spi_start_out),
    .spi_busy_in    (spi_busy_in),
    .ldac_out       (ldac_out),
    .error_out      (error_out),
    .clear_error_in (clear_error_in),
    .points_sent_out(points_sent_out)
  );

  // SPI transmitter stub: busy rises on the edge that sees start, stays high XFER cycles
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 8'd0;
    end else if (stub_busy) begin
      if (stub_cnt == 8'd1) stub_busy <= 1'b0;
      stub_cnt <= stub_cnt - 8'd1;
    end else if (spi_start_out && (stub_mode == 0 || (stub_mode == 2 && !spi_data_out[15]))) begin
      stub_busy <= 1'b1;
      stub_cnt  <= 8'(XFER);
    end
  end

  // Monitor: logs words, idle gaps before each start, LDAC low widths, data stability
  logic [15:0] got_words[$];
  int          gaps[$];
  int          ldac_lens[$];
  int          n_starts   = 0;
  int          stab_err   = 0;
  int          ldac_early = 0;
  int          ldac_run   = 0;
  int          idle_run   = 0;
  logic [15:0] cur_word   = '0;
  bit          in_xfer    = 1'b0;
  bit          seen_busy  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      in_xfer   = 1'b0;
      seen_busy = 1'b0;
      ldac_run  = 0;
      idle_run  = 0;
    end else begin
      if (spi_start_out) begin
        got_words.push_back(spi_data_out);
        gaps.push_back(idle_run);
        n_starts++;
        cur_word  = spi_data_out;
        in_xfer   = 1'b1;
        seen_busy = 1'b0;
      end else if (in_xfer) begin
        if (spi_data_out != cur_word) stab_err++;
        if (spi_busy_in) seen_busy = 1'b1;
        else if (seen_busy) in_xfer = 1'b0;
      end
      if (spi_busy_in) idle_run = 0;
      else if (!spi_start_out) idle_run++;
      if (!ldac_out) begin
        if (ldac_run == 0 && (spi_busy_in || in_xfer || !cur_word[15])) ldac_early++;
        ldac_run++;
      end else if (ldac_run != 0) begin
        ldac_lens.push_back(ldac_run);
        ldac_run = 0;
      end
    end
  end

  // Reference: DAC word = channel select (bit15) + GA 1x (bit13) + active (bit12) + value
  function automatic logic [15:0] dac_word(input bit chan_b, input logic [11:0] v);
    int unsigned w;
    w = 32'h3000 + 32'(v);
    if (chan_b) w = w + 32'h8000;
    return 16'(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!(point_ready_out && !spi_busy_in) && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) chk({tag, "_ready_timeout"}, 32'(n), 32'(BOUND - 1));
  endtask

  // Offer one point and wait for it to complete (count moves) or fail (error rises)
  task automatic do_point(input string tag, input logic [11:0] px, input logic [11:0] py,
                          input bit scramble);
    int          n;
    logic [15:0] c0;
    logic        e0;
    wait_ready(tag);
    c0 = points_sent_out;
    e0 = error_out;
    x_in = px;
    y_in = py;
    point_valid_in = 1'b1;
    tick();
    point_valid_in = 1'b0;
    n = 0;
    while (points_sent_out == c0 && !(error_out && !e0) && n < BOUND) begin
      if (scramble) begin
        x_in = 12'($urandom);
        y_in = 12'($urandom);
      end
      tick();
      n++;
    end
    if (n >= BOUND) chk({tag, "_done_timeout"}, 32'(n), 32'(BOUND - 1));
    tick();
  endtask

  task automatic check_point(input string tag, input int w0, input int l0,
                             input logic [15:0] wx, input logic [15:0] wy,
                             input logic [15:0] expc);
    if (got_words.size() >= w0 + 2) begin
      chk({tag, "_word_x"}, 32'(got_words[w0]), 32'(wx));
      chk({tag, "_word_y"}, 32'(got_words[w0 + 1]), 32'(wy));
      chk({tag, "_gap_ok"}, 32'(gaps[w0 + 1] >= int'(GAP)), 32'd1);
    end else begin
      chk({tag, "_n_words"}, 32'(got_words.size() - w0), 32'd2);
    end
    if (ldac_lens.size() >= l0 + 1) chk({tag, "_ldac_len"}, 32'(ldac_lens[l0]), 32'(LDACN));
    else chk({tag, "_n_ldac"}, 32'(ldac_lens.size() - l0), 32'd1);
    chk({tag, "_count"}, 32'(points_sent_out), 32'(expc));
  endtask

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [15:0] wx;
    logic [15:0] wy;
  } vec_t;

  vec_t        vecs[4];
  logic [11:0] bx[3];
  logic [11:0] by[3];

  initial begin
    int          w0;
    int          l0;
    int          s0;
    int          n;
    int          k;
    int          ready_cnt;
    logic [15:0] c0;
    logic [11:0] rx;
    logic [11:0] ry;

    vecs[0] = '{x: 12'hABC, y: 12'h123, wx: 16'h3ABC, wy: 16'hB123};
    vecs[1] = '{x: 12'h000, y: 12'h000, wx: 16'h3000, wy: 16'hB000};
    vecs[2] = '{x: 12'hFFF, y: 12'hFFF, wx: 16'h3FFF, wy: 16'hBFFF};
    vecs[3] = '{x: 12'h555, y: 12'hAAA, wx: 16'h3555, wy: 16'hBAAA};
    bx = '{12'h111, 12'h7FE, 12'h0F0};
    by = '{12'h222, 12'h801, 12'hF0F};

    rst            = 1'b1;
    x_in           = '0;
    y_in           = '0;
    point_valid_in = 1'b0;
    clear_error_in = 1'b0;
    glitch         = 1'b0;
    stub_mode      = 0;

    // Reset state
    #2;
    chk("rst_ready", 32'(point_ready_out), 32'd0);
    chk("rst_data", 32'(spi_data_out), 32'd0);
    chk("rst_start", 32'(spi_start_out), 32'd0);
    chk("rst_ldac", 32'(ldac_out), 32'd1);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_count", 32'(points_sent_out), 32'd0);
    chk("rst_length", 32'(spi_length_out), 32'd16);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_ready", 32'(point_ready_out), 32'd1);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      w0 = got_words.size();
      l0 = ldac_lens.size();
      s0 = n_starts;
      c0 = points_sent_out;
      do_point("vec", vecs[i].x, vecs[i].y, 1'b1);
      check_point("vec", w0, l0, vecs[i].wx, vecs[i].wy, c0 + 16'd1);
      chk("vec_starts", 32'(n_starts - s0), 32'd2);
    end

    // Back-to-back with valid held high
    wait_ready("b2b");
    w0 = got_words.size();
    l0 = ldac_lens.size();
    c0 = points_sent_out;
    k = 0;
    ready_cnt = 0;
    n = 0;
    x_in = bx[0];
    y_in = by[0];
    point_valid_in = 1'b1;
    while (16'(points_sent_out - c0) != 16'd3 && n < 1000) begin
      if (point_ready_out) begin
        ready_cnt++;
        k++;
      end
      tick();
      n++;
      if (k < 3) begin
        x_in = bx[k];
        y_in = by[k];
      end
    end
    point_valid_in = 1'b0;
    chk("b2b_ready_pulses", 32'(ready_cnt), 32'd3);
    chk("b2b_count", 32'(points_sent_out), 32'(c0 + 16'd3));
    tick();
    for (int i = 0; i < 3; i++) begin
      if (got_words.size() >= w0 + 2 * i + 2) begin
        chk("b2b_word_x", 32'(got_words[w0 + 2 * i]), 32'(dac_word(1'b0, bx[i])));
        chk("b2b_word_y", 32'(got_words[w0 + 2 * i + 1]), 32'(dac_word(1'b1, by[i])));
      end else begin
        chk("b2b_n_words", 32'(got_words.size() - w0), 32'd6);
      end
      if (ldac_lens.size() >= l0 + i + 1) chk("b2b_ldac_len", 32'(ldac_lens[l0 + i]), 32'(LDACN));
      else chk("b2b_n_ldac", 32'(ldac_lens.size() - l0), 32'd3);
    end

    // Randomized points against the word model
    for (int i = 0; i < 12; i++) begin
      n = int'($urandom_range(0, 5));
      for (int j = 0; j < n; j++) tick();
      rx = 12'($urandom);
      ry = 12'($urandom);
      w0 = got_words.size();
      l0 = ldac_lens.size();
      c0 = points_sent_out;
      do_point("rnd", rx, ry, 1'b1);
      check_point("rnd", w0, l0, dac_word(1'b0, rx), dac_word(1'b1, ry), c0 + 16'd1);
    end

    // Busy glitch in IDLE holds off acceptance
    wait_ready("glitch");
    s0 = n_starts;
    glitch = 1'b1;
    point_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_ready", 32'(point_ready_out), 32'd0);
      chk("glitch_no_start", 32'(n_starts - s0), 32'd0);
    end
    glitch = 1'b0;
    point_valid_in = 1'b0;
    tick();

    // X timeout with clear held throughout: set wins, then clear takes effect
    wait_ready("tout1");
    stub_mode = 1;
    s0 = n_starts;
    l0 = ldac_lens.size();
    c0 = points_sent_out;
    clear_error_in = 1'b1;
    point_valid_in = 1'b1;
    x_in = 12'h321;
    y_in = 12'h654;
    tick();
    point_valid_in = 1'b0;
    chk("tout1_start", 32'(spi_start_out), 32'd1);
    for (int i = 0; i < int'(TOUT); i++) begin
      tick();
      chk("tout1_err_early", 32'(error_out), 32'd0);
    end
    tick();
    chk("tout1_set_wins", 32'(error_out), 32'd1);
    tick();
    chk("tout1_cleared", 32'(error_out), 32'd0);
    chk("tout1_ready", 32'(point_ready_out), 32'd1);
    clear_error_in = 1'b0;
    chk("tout1_starts", 32'(n_starts - s0), 32'd1);
    chk("tout1_no_ldac", 32'(ldac_lens.size() - l0), 32'd0);
    chk("tout1_ldac_hi", 32'(ldac_out), 32'd1);
    chk("tout1_count", 32'(points_sent_out), 32'(c0));

    // Second timeout: sticky error, does not block a following point
    do_point("tout2", 12'h0AA, 12'h0BB, 1'b0);
    chk("tout2_err", 32'(error_out), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("tout2_sticky", 32'(error_out), 32'd1);
    stub_mode = 0;
    w0 = got_words.size();
    l0 = ldac_lens.size();
    c0 = points_sent_out;
    do_point("noblock", 12'h9C3, 12'h3C9, 1'b1);
    check_point("noblock", w0, l0, 16'h39C3, 16'hB3C9, c0 + 16'd1);
    chk("noblock_err", 32'(error_out), 32'd1);
    clear_error_in = 1'b1;
    tick();
    clear_error_in = 1'b0;
    chk("clear_pulse", 32'(error_out), 32'd0);

    // Y word never goes busy: error, no LDAC, no count
    stub_mode = 2;
    w0 = got_words.size();
    l0 = ldac_lens.size();
    c0 = points_sent_out;
    do_point("ytout", 12'h2C4, 12'h9E1, 1'b0);
    chk("ytout_err", 32'(error_out), 32'd1);
    chk("ytout_n_words", 32'(got_words.size() - w0), 32'd2);
    if (got_words.size() >= w0 + 1) chk("ytout_word_x", 32'(got_words[w0]), 32'h32C4);
    chk("ytout_no_ldac", 32'(ldac_lens.size() - l0), 32'd0);
    chk("ytout_count", 32'(points_sent_out), 32'(c0));
    stub_mode = 0;
    clear_error_in = 1'b1;
    tick();
    clear_error_in = 1'b0;

    // Reset during the Y transfer
    wait_ready("rstmid");
    s0 = n_starts;
    l0 = ldac_lens.size();
    x_in = 12'h456;
    y_in = 12'h789;
    point_valid_in = 1'b1;
    tick();
    point_valid_in = 1'b0;
    n = 0;
    while (!(n_starts >= s0 + 2 && spi_busy_in) && n < BOUND) begin
      tick();
      n++;
    end
    if (n >= BOUND) chk("rstmid_y_timeout", 32'(n), 32'(BOUND - 1));
    tick();
    tick();
    chk("rstmid_pre_count", 32'(points_sent_out != 16'd0), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_ready", 32'(point_ready_out), 32'd0);
    chk("rstmid_data", 32'(spi_data_out), 32'd0);
    chk("rstmid_start", 32'(spi_start_out), 32'd0);
    chk("rstmid_ldac", 32'(ldac_out), 32'd1);
    chk("rstmid_error", 32'(error_out), 32'd0);
    chk("rstmid_count", 32'(points_sent_out), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("rstmid_no_ldac", 32'(ldac_lens.size() - l0), 32'd0);
    w0 = got_words.size();
    l0 = ldac_lens.size();
    do_point("after_rst", 12'hE01, 12'h10E, 1'b1);
    check_point("after_rst", w0, l0, 16'h3E01, 16'hB10E, 16'd1);

    // Counter wrap from a preloaded 65535
    wait_ready("wrap");
    force dut.points_sent_q = 16'hFFFF;
    tick();
    release dut.points_sent_q;
    tick();
    chk("wrap_preload", 32'(points_sent_out), 32'hFFFF);
    w0 = got_words.size();
    l0 = ldac_lens.size();
    do_point("wrap", 12'h00F, 12'hF00, 1'b1);
    check_point("wrap", w0, l0, 16'h300F, 16'hBF00, 16'h0000);

    // Whole-run invariants
    chk("data_stable", 32'(stab_err), 32'd0);
    chk("ldac_after_y", 32'(ldac_early), 32'd0);
    chk("length_const", 32'(spi_length_out), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=expired want=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/galvo_dac_sequencer.md
Name: galvo_dac_sequencer

Overview:
- Sequences the 16-bit SPI transmitter to drive a dual-channel 12-bit DAC (MCP4822-style): channel A is galvo X, channel B is galvo Y.
- Accepts one (x, y) point per valid/ready handshake and issues two SPI words through the transmitter's start/busy interface.
- Pulses LDAC after both words so X and Y update simultaneously.
- Sits between the point stream (network/frame buffer) and the SPI transmitter instance.

Parameters:
- GAP_CYCLES, 8: idle cycles between end of X word (busy falls) and start of Y word.
- LDAC_CYCLES, 4: length of the active-low LDAC pulse, in clock cycles.
- START_TIMEOUT, 4: cycles to wait for spi_busy_in to rise after a start pulse before flagging an error.
- GAIN_1X, 1: value placed in the DAC word GA bit (1 = 1x gain).

Ports:
- clock_in  input  1  system clock
- reset_in  input  1  asynchronous, active-high reset
- x_in  input  12  X point value
- y_in  input  12  Y point value
- point_valid_in  input  1  point present
- point_ready_out  output  1  sequencer can accept a point
- spi_data_out  output  16  word to SPI transmitter
- spi_length_out  output  6  transfer length, constant 16
- spi_start_out  output  1  one-cycle start pulse to SPI transmitter
- spi_busy_in  input  1  SPI transmitter busy
- ldac_out  output  1  DAC latch strobe, active-low
- error_out  output  1  sticky: SPI failed to go busy after start
- clear_error_in  input  1  clears error_out
- points_sent_out  output  16  count of completed points, wraps at 65535 -> 0

Behaviour:
- Reset (asynchronous, while reset_in=1):
  - state IDLE, point_ready_out=0, spi_data_out=0, spi_start_out=0, ldac_out=1, error_out=0, points_sent_out=0.
  - spi_length_out is constant 16 at all times.
- Timing convention: all outputs are registered.
- States: IDLE, START_X, WAIT_X_HI, WAIT_X_LO, GAP, START_Y, WAIT_Y_HI, WAIT_Y_LO, LDAC.
- IDLE:
  - point_ready_out=1 whenever spi_busy_in=0; otherwise 0.
  - On the edge where point_valid_in & point_ready_out: latch x_in/y_in, set spi_data_out={1'b0,1'b0,GAIN_1X,1'b1,x}, spi_start_out<=1, point_ready_out<=0, go to START_X.
- START_X: spi_start_out high for exactly this one cycle; next edge clears it and enters WAIT_X_HI.
- WAIT_X_HI:
  - spi_busy_in=1 -> WAIT_X_LO.
  - Else after START_TIMEOUT cycles in this state: set error_out, drop the point, return to IDLE. No LDAC, no count increment.
- WAIT_X_LO: busy falls -> GAP with counter loaded to GAP_CYCLES. GAP_CYCLES=0 goes directly to START_Y.
- GAP: counts down. On the edge leaving GAP, set spi_data_out={1'b1,1'b0,GAIN_1X,1'b1,y} and spi_start_out<=1.
- START_Y / WAIT_Y_HI / WAIT_Y_LO: identical rules to the X states, including the timeout.
- Data stability: spi_data_out must hold constant from the start pulse until busy falls, because the transmitter reads data_in live throughout the transfer.
- LDAC:
  - On Y busy fall, ldac_out<=0 for exactly LDAC_CYCLES cycles.
  - Then ldac_out<=1, points_sent_out increments by 1, return to IDLE with point_ready_out<=1.
- Throughput: at most one point per (2 transfers + GAP_CYCLES + LDAC_CYCLES + ~6) cycles.
- Error handling:
  - clear_error_in=1 clears error_out next edge.
  - If a new error occurs in the same cycle as clear_error_in, the set wins.
  - error_out does not block new points.
- point_valid_in deasserted mid-sequence has no effect; the point is already latched. x_in/y_in changes after acceptance are ignored.
- Reset mid-transfer aborts immediately to reset values. The SPI transmitter shares reset_in and aborts too; no LDAC pulse is issued.
- spi_busy_in glitching high while in IDLE holds point_ready_out low; no start is issued while busy.

Test Plan:
- Single point, x=0xABC, y=0x123, GAP_CYCLES=8, LDAC_CYCLES=4, real SPI (PRESCALER small):
  - SPI words 0x3ABC then 0xB123.
  - One start pulse each, >=8 idle cycles between transfers.
  - ldac_out low exactly 4 cycles after second busy fall; points_sent_out=1.
- Back-to-back: valid held high with 3 points:
  - Ready pulses exactly once per point; 6 words in order.
  - points_sent_out=3; no LDAC before each Y word completes.
- Stub busy tied 0:
  - error_out=1 after 4 cycles in WAIT_X_HI; return to IDLE; ldac_out stays 1; count unchanged.
  - clear_error_in pulse -> error_out=0.
- Reset asserted mid Y transfer:
  - All outputs go to reset values asynchronously (before next edge); ldac_out=1; count=0.
  - Next point after release sequences normally.
- Counter wrap: preload via 65536 points (or force) -> points_sent_out wraps 65535->0.
- Data stability: change x_in/y_in every cycle after acceptance -> transmitted words equal the values latched at acceptance.
